axi_lite_uart: RTL and testbench
================================

Name: axi_lite_uart

Overview:
- Synthesizable AXI-Lite UART peripheral (8N1) that terminates the 32-bit AXI-Lite port produced by the SoC's UART width/protocol-conversion chain.
- Replaces the simulation mock on the UART window and drives/samples the SoC `tx`/`rx` pins.
- Contains TX and RX FIFOs, a programmable baud divider, sticky error flags and a level interrupt.

Parameters:
- ADDR_WIDTH, 64: AXI-Lite address width; only addr[7:0] is decoded.
- FIFO_DEPTH, 8: entries per TX and RX FIFO; power of two, ≥2.
- DEFAULT_DIV, 16'd867: reset value of the divider; one bit period = DIV+1 clk cycles.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- axi  slave modport  AXI_LITE(ADDR_WIDTH, 32)  register interface.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous; synchronised internally.
- irq  out  1  level interrupt.

Behaviour:

Register map (addr[7:0]):
- 0x00 TXDATA, write-only: [7:0] pushed to the TX FIFO. Reads return 0.
- 0x04 RXDATA, read: [8] valid, [7:0] data. A read pops the RX FIFO only when valid=1; an empty read returns 0 and does not pop.
- 0x08 STATUS, read: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] tx_busy, [5] rx_ovf, [6] frame_err.
  - Write: bits 5 and 6 are write-1-to-clear; all other bits are ignored.
- 0x0C CTRL, R/W: [15:0] div, [16] rx_ie, [17] tx_ie.
- Any other offset: SLVERR (2'b10), no side effect; reads return 0.

Write channel:
- awready and wready assert together, for one cycle, when awvalid && wvalid && !bvalid.
- The register update happens in that handshake cycle.
- bvalid rises the next cycle and is held until bready.
- TXDATA write with wstrb[0]=0: OKAY, no push.
- TXDATA write when the TX FIFO is full and not popping that cycle: SLVERR, byte dropped.
- CTRL honours wstrb per byte.

Read channel:
- arready is high for one cycle when arvalid && !rvalid.
- rdata/rresp are registered; rvalid rises the next cycle and is held with stable data until rready.
- The RX pop happens in the AR handshake cycle.

FIFOs:
- Simultaneous push and pop is always legal, including when full; count is unchanged.
- Ordering is FIFO.

Transmitter FSM (IDLE → START → DATA → STOP → IDLE):
- IDLE → START the cycle after the TX FIFO is non-empty: pop one byte into the shift register and latch div.
- Each state lasts div+1 cycles.
- DATA sends 8 bits, LSB first.
- STOP → START directly if the FIFO is non-empty.
- tx_busy = state != IDLE.
- A CTRL.div write takes effect at the next frame start.

Receiver:
- 2-flop synchroniser on rx.
- FSM: IDLE → START on a synchronised falling edge.
- In START, sample at (div+1)>>1 cycles: if high, return to IDLE (glitch); otherwise proceed.
- DATA: 8 samples at mid-bit, spaced div+1 apart.
- STOP: mid-bit sample.
  - Sample 0: set frame_err and discard the byte.
  - Sample 1: push the byte. If the FIFO is full and not popping that cycle, set rx_ovf and drop the byte.
- After the STOP sample, return to IDLE and wait for the next falling edge.

irq:
- Registered: irq = (rx_ie && !rx_empty) || (tx_ie && tx_empty && !tx_busy).

Reset (synchronous, priority over everything, including mid-frame and mid-handshake):
- tx=1, irq=0.
- awready, wready, arready, bvalid, rvalid = 0.
- FIFOs empty; both FSMs IDLE; frame in progress abandoned.
- div=DEFAULT_DIV, rx_ie=tx_ie=0, rx_ovf=frame_err=0.

Widths:
- Baud counter is 16 bits.
- div=0 is legal (1 cycle per bit) and must not underflow.

Test Plan (DEFAULT_DIV overridden to 15, i.e. 16 clk/bit):
- Write 0x55 to 0x00 → bresp=OKAY. tx falls ≤2 cycles after the B handshake, then shows 0,1,0,1,0,1,0,1,0,1 in 16-cycle steps. STATUS reads 0x02 after 160 cycles.
- Loop tx→rx; write 0xA5 → after the frame completes, RXDATA reads 0x1A5. A second RXDATA read returns 0x000. STATUS bit2=1.
- With div=0xFFFF, write 10 bytes → writes 1–9 OKAY (one byte in the shifter, 8 in the FIFO), write 10 SLVERR. STATUS[0]=1.
- Drive 9 frames 0x01..0x09 on rx with no reads → STATUS[5]=1. RXDATA returns 0x101..0x108, then 0x000.
- Drive a frame 0x3C with stop bit 0 → STATUS[6]=1, rx_empty=1. Write 0x40 to 0x08 → STATUS[6]=0.
- Read 0x10 → rresp=SLVERR, rdata=0. Assert rst for 1 cycle mid-frame → tx=1, STATUS=0x06, CTRL=0x0000000F (DEFAULT_DIV override) on the next cycle.

Source files
------------

// File: rtl/axi_lite_uart_if.sv
// AXI-Lite bus bundle carrying one register-access port.
//   ADDR_WIDTH : address width of the AW/AR channels
//   DATA_WIDTH : data width of the W/R channels (byte strobes = DATA_WIDTH/8)
// Modports:
//   slave  : peripheral side (accepts AW/W/AR, returns B/R)
//   master : initiator side
interface AXI_LITE #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_uart.sv
// AXI-Lite UART peripheral, 8N1, with TX/RX FIFOs, programmable baud divider,
// sticky error flags and a level interrupt.
//
// axi_lite_uart_fifo : small synchronous FIFO used for both directions.
//   clk, rst          : clock, synchronous active-high reset
//   i_push / i_data   : write strobe and data (caller guarantees room or a same-cycle pop)
//   i_pop             : read strobe (caller guarantees non-empty)
//   o_data            : head entry, valid while !o_empty
//   o_empty / o_full  : occupancy flags
//
// axi_lite_uart (top):
//   clk  : system clock
//   rst  : synchronous active-high reset
//   axi  : AXI-Lite slave register port (32-bit data, addr[7:0] decoded)
//   tx   : serial output, idle high
//   rx   : serial input, asynchronous to clk
//   irq  : registered level interrupt
//
// Register map: 0x00 TXDATA (W), 0x04 RXDATA (R), 0x08 STATUS (R, W1C [6:5]),
//               0x0C CTRL (R/W: [15:0] div, [16] rx_ie, [17] tx_ie).

module axi_lite_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
endmodule

module axi_lite_uart #(
  parameter int          ADDR_WIDTH  = 64,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic clk,
  input  logic rst,
  AXI_LITE.slave axi,
  output logic tx,
  input  logic rx,
  output logic irq
);
  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CTRL   = 8'h0C;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus handshakes and decode
  logic        w_wr_hs;
  logic        w_rd_hs;
  logic [7:0]  w_wr_addr;
  logic [7:0]  w_rd_addr;
  logic        w_tx_wr_sel;
  logic        w_clr_ovf;
  logic        w_clr_ferr;
  logic [31:0] w_status;
  logic [31:0] w_ctrl;

  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  // Control / status
  logic [15:0] r_div;
  logic        r_rx_ie;
  logic        r_tx_ie;
  logic        r_rx_ovf;
  logic        r_frame_err;
  logic        r_irq;

  // FIFOs
  logic        w_tx_push;
  logic        w_tx_pop;
  logic [7:0]  w_tx_head;
  logic        w_tx_empty;
  logic        w_tx_full;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic [7:0]  w_rx_head;
  logic        w_rx_empty;
  logic        w_rx_full;

  // Transmitter
  tx_state_t   r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [15:0] r_tx_div;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bit;
  logic        r_tx;
  logic        w_tx_bit_end;
  logic        w_tx_busy;

  // Receiver
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [15:0] r_rx_div;
  logic [7:0]  r_rx_shift;
  logic [2:0]  r_rx_bit;
  logic        w_rx_fall;
  logic        w_rx_bit_end;
  logic [16:0] w_rx_div_p1;
  logic [15:0] w_rx_half;

  logic        w_unused;

  // ---------------------------------------------------------------------------
  // Handshakes: ready is combinational so the register side effect lands in the
  // same cycle as the handshake. Gated by rst so nothing is accepted in reset.
  // ---------------------------------------------------------------------------
  assign w_wr_hs     = axi.awvalid && axi.wvalid && !r_bvalid && !rst;
  assign w_rd_hs     = axi.arvalid && !r_rvalid && !rst;
  assign axi.awready = w_wr_hs;
  assign axi.wready  = w_wr_hs;
  assign axi.arready = w_rd_hs;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.rvalid  = r_rvalid;
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;

  assign w_wr_addr = axi.awaddr[7:0];
  assign w_rd_addr = axi.araddr[7:0];

  assign w_tx_wr_sel = w_wr_hs && (w_wr_addr == ADDR_TXDATA) && axi.wstrb[0];
  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  assign w_tx_push   = w_tx_wr_sel && (!w_tx_full || w_tx_pop);
  assign w_rx_pop    = w_rd_hs && (w_rd_addr == ADDR_RXDATA) && !w_rx_empty;
  assign w_clr_ovf   = w_wr_hs && (w_wr_addr == ADDR_STATUS) && axi.wstrb[0] && axi.wdata[5];
  assign w_clr_ferr  = w_wr_hs && (w_wr_addr == ADDR_STATUS) && axi.wstrb[0] && axi.wdata[6];

  assign w_status = {25'd0, r_frame_err, r_rx_ovf, w_tx_busy, w_rx_full,
                     w_rx_empty, w_tx_empty, w_tx_full};
  assign w_ctrl   = {14'd0, r_tx_ie, r_rx_ie, r_div};

  // Write channel and CTRL register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_div    <= DEFAULT_DIV;
      r_rx_ie  <= 1'b0;
      r_tx_ie  <= 1'b0;
    end else if (w_wr_hs) begin
      r_bvalid <= 1'b1;
      case (w_wr_addr)
        ADDR_TXDATA: r_bresp <= (w_tx_wr_sel && !w_tx_push) ? RESP_SLVERR : RESP_OKAY;
        ADDR_RXDATA: r_bresp <= RESP_OKAY;
        ADDR_STATUS: r_bresp <= RESP_OKAY;
        ADDR_CTRL: begin
          r_bresp <= RESP_OKAY;
          if (axi.wstrb[0]) r_div[7:0]  <= axi.wdata[7:0];
          if (axi.wstrb[1]) r_div[15:8] <= axi.wdata[15:8];
          if (axi.wstrb[2]) begin
            r_rx_ie <= axi.wdata[16];
            r_tx_ie <= axi.wdata[17];
          end
        end
        default: r_bresp <= RESP_SLVERR;
      endcase
    end else if (r_bvalid && axi.bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read channel: data captured at the AR handshake and held until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_rd_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= RESP_OKAY;
      case (w_rd_addr)
        ADDR_TXDATA: r_rdata <= '0;
        ADDR_RXDATA: r_rdata <= w_rx_empty ? 32'd0 : {23'd0, 1'b1, w_rx_head};
        ADDR_STATUS: r_rdata <= w_status;
        ADDR_CTRL:   r_rdata <= w_ctrl;
        default: begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      endcase
    end else if (r_rvalid && axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  axi_lite_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_data  (axi.wdata[7:0]),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  axi_lite_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  // ---------------------------------------------------------------------------
  // Transmitter. Every state lasts r_tx_div+1 cycles; comparing the counter
  // against the divider (rather than counting down) keeps div=0 safe.
  // ---------------------------------------------------------------------------
  assign w_tx_bit_end = (r_tx_cnt == r_tx_div);
  assign w_tx_busy    = (r_tx_state != TX_IDLE);
  assign w_tx_pop     = !w_tx_empty &&
                        ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= DEFAULT_DIV;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_div   <= r_div;          // divider changes apply per frame
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
            r_tx       <= 1'b0;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
            r_tx       <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TX_STOP;
              r_tx       <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx       <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shift <= w_tx_head;
              r_tx_div   <= r_div;
              r_tx_state <= TX_START;
              r_tx       <= 1'b0;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx = r_tx;

  // ---------------------------------------------------------------------------
  // Receiver. Half-bit offset computed in 17 bits so div=0xFFFF cannot wrap.
  // ---------------------------------------------------------------------------
  assign w_rx_div_p1  = {1'b0, r_rx_div} + 17'd1;
  assign w_rx_half    = w_rx_div_p1[16:1];
  assign w_rx_fall    = r_rx_prev && !r_rx_s2;
  assign w_rx_bit_end = (r_rx_cnt == r_rx_div);
  assign w_rx_push    = (r_rx_state == RX_STOP) && w_rx_bit_end && r_rx_s2 &&
                        (!w_rx_full || w_rx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_div    <= DEFAULT_DIV;
      r_rx_shift  <= '0;
      r_rx_bit    <= '0;
      r_rx_ovf    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      // Clears first so an error detected in the same cycle still sticks.
      if (w_clr_ovf)  r_rx_ovf    <= 1'b0;
      if (w_clr_ferr) r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= '0;
            r_rx_div   <= r_div;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == w_rx_half) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            // Line back high at mid start bit: treat as a glitch.
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (!r_rx_s2) begin
              r_frame_err <= 1'b1;
            end else if (w_rx_full && !w_rx_pop) begin
              r_rx_ovf <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_rx_ie && !w_rx_empty) || (r_tx_ie && w_tx_empty && !w_tx_busy);
    end
  end

  assign irq = r_irq;

  // Address bits above the decoded window and reserved data bits are ignored.
  assign w_unused = ^{axi.awaddr[ADDR_WIDTH-1:8], axi.araddr[ADDR_WIDTH-1:8],
                      axi.wdata[31:18], axi.wstrb[3], w_rx_div_p1[0]};
endmodule

// File: tb/tb_axi_lite_uart.sv
module tb_axi_lite_uart;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx_drv;
  logic loop_en;
  logic tx_w;
  logic rx_w;
  logic irq_w;

  assign rx_w = loop_en ? tx_w : rx_drv;

  AXI_LITE #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

  axi_lite_uart #(
    .ADDR_WIDTH  (64),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .axi (bus),
    .tx  (tx_w),
    .rx  (rx_w),
    .irq (irq_w)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic to;
    to = 1'b0;
    bus.awaddr  = {56'd0, addr};
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    #1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) to = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    #1;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) to = 1'b1;
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("wr_timeout", {31'd0, to}, 32'd0);
    $display("WR addr=0x%02h data=0x%08h strb=%b bresp=%0d", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    logic to;
    to = 1'b0;
    bus.araddr  = {56'd0, addr};
    bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) to = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    #1;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) to = 1'b1;
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check("rd_timeout", {31'd0, to}, 32'd0);
    $display("RD addr=0x%02h rdata=0x%08h rresp=%0d", addr, data, resp);
  endtask

  // Drives one 16-cycle-per-bit frame onto rx with the given stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frm;
    frm = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = frm[k];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("RXFRAME data=0x%02h stop=%0d", b, stop_bit);
  endtask

  // Samples tx at mid-bit for one frame, starting just after the falling edge.
  task automatic expect_tx_frame(input logic [7:0] b);
    logic [9:0] frm;
    int n;
    frm = {1'b1, b, 1'b0};
    n = 0;
    while (tx_w !== 1'b0 && n < 3) begin
      @(posedge clk); #1; n++;
    end
    check("tx_start_latency", {31'd0, tx_w}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), {31'd0, tx_w}, {31'd0, frm[k]});
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    rst = 1'b1;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_tx", {31'd0, tx_w}, 32'd1);
    check("rst_irq", {31'd0, irq_w}, 32'd0);
    check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    axi_read(8'h08, d, r);
    check("rst_status", d, 32'h06);
    axi_read(8'h0C, d, r);
    check("rst_ctrl", d, 32'h0000000F);

    // Transmit 0x55 looped back into the receiver
    loop_en = 1'b1;
    axi_write(8'h00, 32'h55, 4'hF, r);
    check("tx55_bresp", {30'd0, r}, 32'd0);
    expect_tx_frame(8'h55);
    repeat (20) @(posedge clk);
    #1;
    axi_read(8'h08, d, r);
    check("status_after_tx55", d, 32'h02);
    check("irq_disabled", {31'd0, irq_w}, 32'd0);
    axi_write(8'h0C, 32'h0001000F, 4'hF, r);
    check("irq_rx_ie", {31'd0, irq_w}, 32'd1);
    axi_read(8'h04, d, r);
    check("rxdata_55", d, 32'h155);
    repeat (2) @(posedge clk);
    #1;
    check("irq_rx_drained", {31'd0, irq_w}, 32'd0);
    axi_write(8'h0C, 32'h0000000F, 4'hF, r);

    // Loopback 0xA5, then empty read
    axi_write(8'h00, 32'hA5, 4'hF, r);
    check("txA5_bresp", {30'd0, r}, 32'd0);
    repeat (180) @(posedge clk);
    #1;
    axi_read(8'h04, d, r);
    check("rxdata_A5", d, 32'h1A5);
    axi_read(8'h04, d, r);
    check("rxdata_empty", d, 32'h000);
    axi_read(8'h08, d, r);
    check("status_rx_empty", d, 32'h06);

    // TXDATA write without byte-0 strobe: OKAY, nothing queued
    axi_write(8'h00, 32'h77, 4'hE, r);
    check("tx_nostrb_bresp", {30'd0, r}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    axi_read(8'h08, d, r);
    check("tx_nostrb_status", d, 32'h06);

    // Unmapped write and TXDATA read
    axi_write(8'h10, 32'h1234, 4'hF, r);
    check("wr_bad_addr_bresp", {30'd0, r}, 32'd2);
    axi_read(8'h00, d, r);
    check("rd_txdata", d, 32'd0);
    check("rd_txdata_rresp", {30'd0, r}, 32'd0);

    // tx_ie interrupt and byte-lane CTRL write
    axi_write(8'h0C, 32'h0002000F, 4'hF, r);
    repeat (2) @(posedge clk);
    #1;
    check("irq_tx_ie", {31'd0, irq_w}, 32'd1);
    axi_write(8'h0C, 32'h00000000, 4'h4, r);
    axi_read(8'h0C, d, r);
    check("ctrl_lane2_only", d, 32'h0000000F);
    repeat (2) @(posedge clk);
    #1;
    check("irq_tx_ie_off", {31'd0, irq_w}, 32'd0);

    // Slow divider, overfill TX FIFO
    loop_en = 1'b0;
    axi_write(8'h0C, 32'h0000FFFF, 4'h3, r);
    axi_read(8'h0C, d, r);
    check("ctrl_div_ffff", d, 32'h0000FFFF);
    for (int i = 1; i <= 10; i++) begin
      axi_write(8'h00, 32'h30 + i, 4'hF, r);
      check($sformatf("fill_bresp%0d", i), {30'd0, r}, (i <= 9) ? 32'd0 : 32'd2);
    end
    axi_read(8'h08, d, r);
    check("status_tx_full", d, 32'h15);
    check("tx_mid_start", {31'd0, tx_w}, 32'd0);
    axi_read(8'h10, d, r);
    check("rd_bad_addr_rresp", {30'd0, r}, 32'd2);
    check("rd_bad_addr_rdata", d, 32'd0);

    // Reset mid-frame
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_tx", {31'd0, tx_w}, 32'd1);
    check("midrst_irq", {31'd0, irq_w}, 32'd0);
    axi_read(8'h08, d, r);
    check("midrst_status", d, 32'h06);
    axi_read(8'h0C, d, r);
    check("midrst_ctrl", d, 32'h0000000F);

    // Nine frames, no reads: overflow on the ninth
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1);
    end
    axi_read(8'h08, d, r);
    check("status_rx_ovf", d, 32'h2A);
    for (int i = 1; i <= 8; i++) begin
      axi_read(8'h04, d, r);
      check($sformatf("rx_order%0d", i), d, 32'h100 + i);
    end
    axi_read(8'h04, d, r);
    check("rx_order_empty", d, 32'h000);

    // Framing error and selective W1C
    send_frame(8'h3C, 1'b0);
    axi_read(8'h08, d, r);
    check("status_frame_err", d, 32'h66);
    axi_write(8'h08, 32'h40, 4'hF, r);
    check("w1c_bresp", {30'd0, r}, 32'd0);
    axi_read(8'h08, d, r);
    check("status_ferr_clr", d, 32'h26);
    axi_write(8'h08, 32'h20, 4'hF, r);
    axi_read(8'h08, d, r);
    check("status_ovf_clr", d, 32'h06);

    // Receiver recovers after a framing error
    send_frame(8'h5A, 1'b1);
    axi_read(8'h04, d, r);
    check("rx_after_ferr", d, 32'h15A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
